// File: rtl/mux_fade_pkg.sv
// rtl/mux_fade_pkg.sv - shared types and gain scaling rule for the fading source selector
package mux_fade_pkg;

    typedef enum logic [1:0] {
        PASS     = 2'd0,
        FADE_OUT = 2'd1,
        FADE_IN  = 2'd2
    } fade_state_e;

    localparam int FADE_LOG2_DEF = 4;
    localparam int FADE_M        = 1 << FADE_LOG2_DEF;

    function automatic int fade_m(input int fade_log2);
        return 1 << fade_log2;
    endfunction

    // Exact signed product, then floor division by 2**shift; callers keep the low WIDTH bits.
    function automatic logic signed [63:0] gain_scale(
        input logic signed [31:0] sample,
        input logic        [8:0]  g,
        input int                 shift
    );
        logic signed [63:0] prod;
        prod = $signed({{32{sample[31]}}, sample}) * $signed({55'd0, g});
        return prod >>> shift;
    endfunction

endpackage

// File: rtl/mux_nto1_fade_gain.sv
// rtl/mux_nto1_fade_gain.sv - combinational sample * g / 2**FADE_LOG2 gain stage
module amp_gain_scale
    import mux_fade_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int FADE_LOG2 = 4
) (
    input  logic [WIDTH-1:0]   sample,
    input  logic [FADE_LOG2:0] gain,
    output logic [WIDTH-1:0]   scaled
);

    assign scaled = WIDTH'(gain_scale(32'($signed(sample)), 9'(gain), FADE_LOG2));

endmodule

// File: rtl/mux_nto1_fade.sv
// rtl/mux_nto1_fade.sv - click-free N-channel source selector with per-sample gain ramps
module mux_nto1_fade
    import mux_fade_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int N_CH      = 5,
    parameter int SEL_W     = 4,
    parameter int FADE_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic [SEL_W-1:0]      sel,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    output logic                  busy,
    output logic [SEL_W-1:0]      cur_sel
);

    localparam int M  = fade_m(FADE_LOG2);
    localparam int GW = FADE_LOG2 + 1;
    localparam logic [GW-1:0] G_MAX = GW'(M);
    localparam int N_SLOT = 1 << SEL_W;

    fade_state_e      state, state_nxt;
    logic [GW-1:0]    g, g_nxt;
    logic [SEL_W-1:0] cur_nxt;
    logic [SEL_W-1:0] tgt;
    logic             req;
    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] scaled;
    logic [WIDTH-1:0] chan [N_SLOT];

    // Unused select codes become silent channels so a fade to them acts as a mute.
    for (genvar k = 0; k < N_SLOT; k++) begin : g_chan
        if (k < N_CH) begin : g_real
            assign chan[k] = in_data[k*WIDTH +: WIDTH];
        end else begin : g_mute
            assign chan[k] = '0;
        end
    end

    assign src = chan[cur_sel];

    amp_gain_scale #(
        .WIDTH     (WIDTH),
        .FADE_LOG2 (FADE_LOG2)
    ) u_gain (
        .sample (src),
        .gain   (g),
        .scaled (scaled)
    );

    // A change on sel is latched into tgt and acted on by the FSM one clk later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt <= '0;
            req <= 1'b0;
        end else begin
            req <= (sel != tgt);
            if (sel != tgt) tgt <= sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= PASS;
            g       <= G_MAX;
            cur_sel <= '0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            g       <= g_nxt;
            cur_sel <= cur_nxt;
            busy    <= (state_nxt != PASS);
        end
    end

    // Gain steps follow the current state; a redirecting request wins the next state.
    always_comb begin
        state_nxt = state;
        g_nxt     = g;
        cur_nxt   = cur_sel;
        case (state)
            PASS: begin
                g_nxt = G_MAX;
                if (req && tgt != cur_sel) state_nxt = FADE_OUT;
            end
            FADE_OUT: begin
                if (in_valid) begin
                    if (g != '0) begin
                        g_nxt = g - 1'b1;
                    end else begin
                        cur_nxt   = tgt;
                        g_nxt     = GW'(1);
                        state_nxt = FADE_IN;
                    end
                end
                if (req && tgt == cur_sel) state_nxt = FADE_IN;
            end
            FADE_IN: begin
                if (in_valid) begin
                    if (g != G_MAX) g_nxt = g + 1'b1;
                    else            state_nxt = PASS;
                end
                if (req && tgt != cur_sel) state_nxt = FADE_OUT;
            end
            default: begin
                state_nxt = PASS;
                g_nxt     = G_MAX;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) out_data <= scaled;
        end
    end

endmodule

// File: doc/mux_nto1_fade.md
Name: mux_nto1_fade

Overview:
Click-free N-channel audio source selector for the signal-generator/amp path: a parametrised successor to the 5-way combinational selector.
On a channel change it fades the old source to zero, switches, then fades the new source up, one gain step per sample strobe.
The output is registered and aligned to the sample strobe, so it can drive the amplitude stage directly.

Parameters:
WIDTH, 16, signed sample width of every input and of the output.
N_CH, 5, number of input channels (2..16).
SEL_W, 4, width of sel; must satisfy 2**SEL_W >= N_CH.
FADE_LOG2, 4, fade length exponent; M = 2**FADE_LOG2 gain steps per ramp (1..8).

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous active-low reset.
in_data  input  N_CH*WIDTH  packed signed samples; channel k occupies bits [k*WIDTH +: WIDTH].
in_valid  input  1  one-cycle sample strobe.
sel  input  SEL_W  requested channel, sampled every clk.
out_data  output  WIDTH  registered, gain-scaled signed sample.
out_valid  output  1  one-cycle pulse, one clk after in_valid.
busy  output  1  high while fading (state != PASS).
cur_sel  output  SEL_W  channel currently routed to the output.

Behaviour:
- Reset (async, rst_n=0): state=PASS, cur_sel=0, tgt=0, g=M, out_data=0, out_valid=0, busy=0.
- Gain g is unsigned, FADE_LOG2+1 bits, with range 0..M.
- Scaling: the signed product is in[cur_sel]*g, computed at WIDTH+FADE_LOG2+2 bits, then arithmetic-shifted right by FADE_LOG2 and truncated to WIDTH bits.
  - g=M gives exact passthrough.
  - The shift truncates toward negative infinity.
- Out-of-range sel (>= N_CH): the selected source reads as 0, and fades still apply. This makes it a mute channel.
- Latency: on the clk where in_valid=1, out_data is loaded with scale(in[cur_sel], g), using the pre-update cur_sel and g. out_valid=1 on the following cycle. Otherwise out_data holds and out_valid=0.
- Request detection: every clk, if sel != tgt then tgt <= sel. The state change below takes effect the next clk. A request arriving on the same clk as in_valid does not affect that sample.
- State machine (g and cur_sel update only on in_valid clks unless stated):
  - PASS: g=M.
    - New request with sel != cur_sel -> FADE_OUT.
    - New request with sel == cur_sel -> stay in PASS.
  - FADE_OUT: on in_valid with g>0: g <= g-1.
    - On in_valid with g==0: cur_sel <= tgt, g <= 1, -> FADE_IN. The output for that sample is 0.
    - Request with sel == cur_sel -> FADE_IN from the current g, with no switch.
    - Request with another channel: only tgt updates.
  - FADE_IN: on in_valid with g<M: g <= g+1.
    - On in_valid with g==M -> PASS.
    - Request with sel != cur_sel -> FADE_OUT from the current g.
- Full switch from PASS takes 2M+1 samples. Output gain sequence: M, M-1, ..., 1, 0 on the old channel, then 1, ..., M on the new channel.
- busy = (state != PASS), registered with the state.
- in_data is not registered internally; it must be stable on in_valid clks.
- Reset mid-fade: returns immediately to reset values, with channel 0 at full gain.

Decomposition:
- Package mux_fade_pkg holds:
  - state enum fade_state_e {PASS, FADE_OUT, FADE_IN} (2-bit);
  - function gain_scale(sample, g) implementing the multiply/shift/truncate rule;
  - the localparam for M.
- Sub-module amp_gain_scale: purely combinational, parametrised on WIDTH and FADE_LOG2, reusable by the amp stage. The FSM, counter and channel index stay in mux_nto1_fade.

Test Plan:
- Reset, then feed in0=1000 with sel=0 and in_valid every 4th clk -> out_data=1000 one clk after each strobe; busy=0; cur_sel=0.
- FADE_LOG2=2, in0=1000, in1=-1000: switch sel 0->1 -> successive outputs 1000, 750, 500, 250, 0, -250, -500, -750, -1000. busy is high from the clk after the change until the -1000 sample; cur_sel becomes 1 after the 0 sample.
- Same setup, return sel to 0 after the 500 output -> outputs 250, 500, 750, 1000 on channel 0, cur_sel never changes, then PASS.
- Switch 0->1, then sel=2 (in2=400) during FADE_IN at g=2 -> outputs fade down from the current g, -500 then -250 (g=2,1), then 0, then 100, 200, 300, 400; cur_sel=2.
- sel=7 with N_CH=5 -> fade to 0 and stay at 0 output; cur_sel=7.
- Assert rst_n=0 mid FADE_OUT -> out_data=0, out_valid=0, busy=0, cur_sel=0 immediately (asynchronously); the next strobe passes in0 at full gain.
